pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Two-entry valid/ready skid buffer placed directly upstream of each 75-bit inter-stage pipeline register in the out-of-order core.
- Decouples the producing stage's backpressure from the consuming stage's stall, so the consumer register can be loaded from out_data with enable = out_valid & out_ready.
- Registered in_ready: no combinational ready path from consumer back to producer.
- Full throughput of 1 payload/cycle. softReset provides a pipeline flush.

Parameters:
- WIDTH, 75, payload width in bits.
- CNT_W, 16, stall-counter width. Used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; highest priority.
- softReset  input  1  synchronous, active-high flush; priority below reset.
- in_valid  input  1  producer has payload.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  producer payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  payload; driven directly from the main register.
- stall_cnt  output  CNT_W  only present with PIPE_SKID_STALL_CNT_EN.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - Synchronous, active-high reset.
- Storage: main register M and skid register S. States:
  - EMPTY: M and S invalid.
  - BUSY: M valid, S invalid.
  - FULL: M and S valid.
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), decoded from a state flop.
  - out_data = M.
- Handshakes:
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - Payload appears on out_data exactly 1 cycle after an in-transfer when M is free.
- Transitions (evaluated at posedge, reset/softReset clear):
  - EMPTY, in_valid: M<=in_data; go BUSY.
  - EMPTY, no in_valid: stay EMPTY.
  - BUSY, in_valid & out_ready: M<=in_data; stay BUSY.
  - BUSY, in_valid & !out_ready: S<=in_data; go FULL.
  - BUSY, !in_valid & out_ready: go EMPTY.
  - BUSY, neither: hold.
  - FULL, out_ready: M<=S; go BUSY. in_data is ignored because in_ready=0.
  - FULL, !out_ready: hold. M and S stay stable.
- Ordering: payloads leave strictly in arrival order. No loss and no duplication.
- reset: state<=EMPTY; M<=0, S<=0; in_ready=1, out_valid=0 from the next cycle.
- softReset (flush):
  - Same effect as reset on state, M and S.
  - An in_valid in the same cycle is dropped.
  - An out-transfer in the same cycle still counts as consumed by the consumer.
- reset together with softReset: reset semantics.
- Output stability: out_data does not change while out_valid & !out_ready, except on reset or softReset.
- in_valid while in_ready=0: ignored. The producer must hold its data.
- X-safety: in_data is not sampled unless a transfer occurs.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Counts cycles with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared to 0 by reset only; softReset does not clear it.
  - Updates with 1-cycle latency.
- Undefined: stall_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package pipe_skid_pkg holds:
  - PIPE_PAYLOAD_W = 75.
  - PIPE_STALL_CNT_W = 16.
  - typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_t.
- One natural sub-module: skid_entry_reg, a WIDTH-wide register with load enable and synchronous clear. It is instantiated twice, for M and S.
- State machine and handshake logic live in pipe_skid_stage.

Test Plan:
- Reset: reset=1 for 2 cycles -> in_ready=1, out_valid=0, out_data=0; stall_cnt=0 if enabled.
- Streaming: in_valid=1 with data 0x1, 0x2, 0x3 on consecutive cycles, out_ready=1 -> out_data 0x1, 0x2, 0x3 one cycle later each, out_valid=1 throughout, in_ready never drops.
- Backpressure:
  - Stimulus: send 0xA then 0xB; out_ready=0 from the cycle 0xB is offered.
  - Expected: FULL; in_ready=0; out_data=0xA stable for 5 stalled cycles; stall_cnt=5 if enabled.
  - Then out_ready=1: out_data 0xA, then 0xB; in_ready=1 the cycle after the first pop.
- Flush: in FULL holding 0x7 and 0x8, assert softReset with in_valid=1 and data 0x9 -> next cycle out_valid=0, in_ready=1; 0x7, 0x8 and 0x9 are never output.
- Overflow guard: in FULL, toggle in_data randomly with in_valid=1 -> in_data is ignored while in_ready=0; the output sequence matches a scoreboard of accepted transfers only.
- Random: 10k cycles of random in_valid/out_ready with a reference FIFO scoreboard -> in-order, lossless delivery; saturation check with CNT_W=4 forced gives stall_cnt holding at 15.

Source files
------------

// File: rtl/pipe_skid_pkg.sv
// Shared types and widths for the two-entry pipeline skid buffer.
package pipe_skid_pkg;

  localparam int unsigned PIPE_PAYLOAD_W   = 75;
  localparam int unsigned PIPE_STALL_CNT_W = 16;

  // Occupancy of the main (M) and skid (S) entries.
  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_BUSY,
    SKID_FULL
  } skid_state_t;

endpackage

// File: rtl/skid_entry_reg.sv
// One payload entry of the skid buffer: load-enabled register with synchronous clear.
module skid_entry_reg #(
  parameter int unsigned WIDTH = 75
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Clear wins over load so a flush never leaves stale payload behind.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid buffer with registered in_ready.
// Optional stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage
  import pipe_skid_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_PAYLOAD_W,
  parameter int unsigned CNT_W = PIPE_STALL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  skid_state_t      state_q;
  logic             flush;
  logic             m_load;
  logic             s_load;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;

  assign flush = reset | softReset;

  // Handshake outputs decode straight from the state flop, so ready never
  // depends combinationally on out_ready.
  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = (state_q != SKID_FULL);
  assign out_data  = m_q;

  // Entry load enables; in_data is only captured on an actual in-transfer.
  always_comb begin
    m_load = 1'b0;
    s_load = 1'b0;
    m_d    = in_data;
    case (state_q)
      SKID_EMPTY: m_load = in_valid;
      SKID_BUSY: begin
        m_load = in_valid & out_ready;
        s_load = in_valid & ~out_ready;
      end
      SKID_FULL: begin
        m_load = out_ready;
        m_d    = s_q;
      end
      default: begin
        m_load = 1'b0;
        s_load = 1'b0;
      end
    endcase
  end

  // Occupancy state machine; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (in_valid) state_q <= SKID_BUSY;
        SKID_BUSY: begin
          if (in_valid && !out_ready) begin
            state_q <= SKID_FULL;
          end else if (!in_valid && out_ready) begin
            state_q <= SKID_EMPTY;
          end
        end
        SKID_FULL: if (out_ready) state_q <= SKID_BUSY;
        default: state_q <= SKID_EMPTY;
      endcase
    end
  end

  skid_entry_reg #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk_i (clk),
    .clr_i (flush),
    .en_i  (m_load),
    .d_i   (m_d),
    .q_o   (m_q)
  );

  skid_entry_reg #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i (clk),
    .clr_i (flush),
    .en_i  (s_load),
    .d_i   (in_data),
    .q_o   (s_q)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled-output cycles; survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CntOne;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Counter width is meaningless without the counter.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
